// File: rtl/led_heartbeat_if.sv
// Control/status bundle for led_heartbeat. The master drives modes, periods, duties and sync.
// The slave (the LED driver) returns the LED bus and the prescaler tick.
interface led_heartbeat_if #(
  parameter int NCH      = 4,
  parameter int PWM_BITS = 8
);
  logic [2*NCH-1:0]      mode;
  logic [16*NCH-1:0]     half_period;
  logic [PWM_BITS*NCH-1:0] duty;
  logic                  sync;
  logic [NCH-1:0]        led;
  logic                  tick;

  modport master (
    output mode,
    output half_period,
    output duty,
    output sync,
    input  led,
    input  tick
  );

  modport slave (
    input  mode,
    input  half_period,
    input  duty,
    input  sync,
    output led,
    output tick
  );
endinterface

// File: rtl/led_heartbeat.sv
// Multi-channel LED driver: shared tick prescaler, per-channel off/on/blink/PWM, 1-cycle registered output.
// Define LED_BREATHE_EN to make mode 11 follow an internal triangle ramp instead of duty.
module led_heartbeat #(
  parameter int NCH      = 4,
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int PWM_BITS = 8
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  led_heartbeat_if.slave bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] DIV_M1 = PW'(DIV - 1);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_PWM   = 2'b11;

  logic [PW-1:0]       pre_q, pre_d;
  logic                tick_q, tick_d;
  logic                tick_ev;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;

  // sync suppresses a coincident tick so every channel restarts from a clean phase.
  always_comb begin
    tick_ev = (pre_q == DIV_M1) && !bus.sync;
    tick_d  = tick_ev;
    if (bus.sync || (pre_q == DIV_M1)) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PW'(1);
    end
    pwm_d = pwm_q + PWM_BITS'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      pwm_q  <= '0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      pwm_q  <= pwm_d;
    end
  end

  assign bus.tick = tick_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [1:0]          mode_in;
    logic [15:0]         hp_in;
    logic [15:0]         hp_m1;
    logic                entry;
    logic [PWM_BITS-1:0] duty_eff;

    logic [15:0] cnt_q, cnt_d;
    logic        ph_q, ph_d;
    logic [1:0]  mode_q, mode_d;
    logic        led_q, led_d;

    assign mode_in = bus.mode[2*g +: 2];
    assign hp_in   = bus.half_period[16*g +: 16];
    // A zero half-period behaves as one: toggle on every tick.
    assign hp_m1   = (hp_in == 16'd0) ? 16'd0 : (hp_in - 16'd1);
    assign entry   = bus.sync || (mode_in != mode_q);

    always_comb begin
      cnt_d  = cnt_q;
      ph_d   = ph_q;
      mode_d = mode_in;
      if (entry) begin
        cnt_d = 16'd0;
        ph_d  = 1'b1;
      end else if (tick_ev && (mode_in == MODE_BLINK)) begin
        if (cnt_q >= hp_m1) begin
          cnt_d = 16'd0;
          ph_d  = ~ph_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    end

`ifdef LED_BREATHE_EN
    logic [PWM_BITS-1:0] br_q, br_d;
    logic                dn_q, dn_d;

    // Triangle ramp; each endpoint is held for one tick while the direction flips.
    always_comb begin
      br_d = br_q;
      dn_d = dn_q;
      if (entry) begin
        br_d = '0;
        dn_d = 1'b0;
      end else if (tick_ev && (mode_in == MODE_PWM)) begin
        if (!dn_q) begin
          if (&br_q) dn_d = 1'b1;
          else       br_d = br_q + PWM_BITS'(1);
        end else begin
          if (br_q == '0) dn_d = 1'b0;
          else            br_d = br_q - PWM_BITS'(1);
        end
      end
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        br_q <= '0;
        dn_q <= 1'b0;
      end else begin
        br_q <= br_d;
        dn_q <= dn_d;
      end
    end

    assign duty_eff = br_d;
`else
    assign duty_eff = bus.duty[PWM_BITS*g +: PWM_BITS];
`endif

    // Select from the live mode and next phase so a change shows on led one cycle later.
    always_comb begin
      unique case (mode_in)
        MODE_OFF:   led_d = 1'b0;
        MODE_ON:    led_d = 1'b1;
        MODE_BLINK: led_d = ph_d;
        MODE_PWM:   led_d = (pwm_q < duty_eff);
        default:    led_d = 1'b0;
      endcase
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        cnt_q  <= 16'd0;
        ph_q   <= 1'b0;
        mode_q <= MODE_OFF;
        led_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        ph_q   <= ph_d;
        mode_q <= mode_d;
        led_q  <= led_d;
      end
    end

    assign bus.led[g] = led_q;
  end

endmodule

// File: tb/tb_led_heartbeat.sv
// Scoreboarded bench for led_heartbeat: a spec-level model predicts led/tick per cycle, plus directed timing checks.
module tb_led_heartbeat;

  localparam int NCH      = 4;
  localparam int PWM_BITS = 4;
  localparam int CLK_HZ   = 1000;
  localparam int TICK_HZ  = 100;
  localparam int DIV      = CLK_HZ / TICK_HZ;
  localparam int PWM_N    = 1 << PWM_BITS;

  typedef struct packed {
    logic [NCH-1:0] led;
    logic           tick;
  } exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  led_heartbeat_if #(.NCH(NCH), .PWM_BITS(PWM_BITS)) bus_if ();

  led_heartbeat #(
    .NCH(NCH), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .PWM_BITS(PWM_BITS)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus_if)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb_q[$];
  logic [NCH-1:0] led_s;
  logic           tick_s;

  // Reference model state: cycles since reset (pwm phase), prescaler phase,
  // ticks since each channel's last entry/sync, and the last seen modes.
  int             m_cyc;
  int             m_pre;
  int             m_ticks[NCH];
  logic [2*NCH-1:0] m_mq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(output exp_t e);
    bit   tev;
    int   hp;
    int   lvl;
    logic [1:0] md;
    e = '0;
    if (sys_rst) begin
      m_cyc = 0;
      m_pre = 0;
      m_mq  = '0;
      for (int i = 0; i < NCH; i++) m_ticks[i] = 0;
      return;
    end
    tev    = (m_pre == DIV - 1) && !bus_if.sync;
    e.tick = tev;
    m_pre  = bus_if.sync ? 0 : (m_pre + 1) % DIV;
    for (int i = 0; i < NCH; i++) begin
      md = bus_if.mode[2*i +: 2];
      if (bus_if.sync || (md != m_mq[2*i +: 2])) m_ticks[i] = 0;
      else if (tev) m_ticks[i]++;
      hp = int'(bus_if.half_period[16*i +: 16]);
      if (hp == 0) hp = 1;
`ifdef LED_BREATHE_EN
      lvl = m_ticks[i] % (2 * PWM_N);
      if (lvl >= PWM_N) lvl = 2 * PWM_N - 1 - lvl;
`else
      lvl = int'(bus_if.duty[PWM_BITS*i +: PWM_BITS]);
`endif
      case (md)
        2'b00: e.led[i] = 1'b0;
        2'b01: e.led[i] = 1'b1;
        2'b10: e.led[i] = ((m_ticks[i] / hp) % 2) == 0;
        default: e.led[i] = (m_cyc % PWM_N) < lvl;
      endcase
    end
    m_mq = bus_if.mode;
    m_cyc++;
  endtask

  task automatic step();
    exp_t e;
    exp_t p;
    model_step(e);
    sb_q.push_back(e);
    @(posedge sys_clk);
    #1;
    led_s  = bus_if.led;
    tick_s = bus_if.tick;
    p = sb_q.pop_front();
    check("sb_led", 32'(led_s), 32'(p.led));
    check("sb_tick", 32'(tick_s), 32'(p.tick));
  endtask

  task automatic measure_toggles(input int ch, input int ncyc, input int exp_gap, input string tag);
    logic prev;
    int   last;
    int   n;
    prev = led_s[ch];
    last = -1;
    n    = 0;
    for (int k = 1; k <= ncyc; k++) begin
      step();
      if (led_s[ch] != prev) begin
        if (last >= 0) check(tag, k - last, exp_gap);
        last = k;
        prev = led_s[ch];
        n++;
      end
    end
    check({tag, "_count"}, 32'(n >= 3), 1);
  endtask

  task automatic count_high(input int ch, input int exp_n, input string tag);
    int n;
    n = 0;
    for (int k = 0; k < PWM_N; k++) begin
      step();
      if (led_s[ch]) n++;
    end
`ifndef LED_BREATHE_EN
    check(tag, n, exp_n);
`endif
  endtask

  task automatic cycles_to_tick(input string tag);
    int first;
    first = -1;
    for (int k = 1; k <= 2 * DIV; k++) begin
      step();
      if (tick_s && first < 0) first = k;
    end
    check(tag, first, DIV);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus_if.mode        = '0;
    bus_if.half_period = '0;
    bus_if.duty        = '0;
    bus_if.sync        = 1'b0;
    sys_rst            = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("rst_led", 32'(led_s), 0);
    check("rst_tick", 32'(tick_s), 0);

    // Idle: all off, first tick DIV cycles after release, then every DIV.
    sys_rst = 1'b0;
    cycles_to_tick("first_tick");
    check("idle_led", 32'(led_s), 0);

    // ch0 blink, half-period 3 ticks.
    bus_if.half_period[15:0] = 16'd3;
    bus_if.mode[1:0]         = 2'b10;
    step();
    check("ch0_entry_lit", 32'(led_s[0]), 1);
    measure_toggles(0, 130, 3 * DIV, "ch0_half");

    // ch1 blink with zero half-period toggles every tick.
    bus_if.half_period[31:16] = 16'd0;
    bus_if.mode[3:2]          = 2'b10;
    step();
    check("ch1_entry_lit", 32'(led_s[1]), 1);
    measure_toggles(1, 50, DIV, "ch1_half");

    // ch2 PWM duty sweep including both bounds.
    bus_if.duty[11:8] = 4'd4;
    bus_if.mode[5:4]  = 2'b11;
    step();
    count_high(2, 4, "pwm_duty4");
    bus_if.duty[11:8] = 4'd0;
    count_high(2, 0, "pwm_duty0");
    bus_if.duty[11:8] = 4'd15;
    count_high(2, 15, "pwm_duty15");

    // ch3 blinks at a different rate, then sync realigns both blinkers.
    bus_if.half_period[63:48] = 16'd5;
    bus_if.mode[7:6]          = 2'b10;
    for (int k = 0; k < 37; k++) step();
    for (int k = 0; k < DIV && m_pre != 5; k++) step();
    bus_if.sync = 1'b1;
    step();
    bus_if.sync = 1'b0;
    check("sync_ch0_lit", 32'(led_s[0]), 1);
    check("sync_ch3_lit", 32'(led_s[3]), 1);
    cycles_to_tick("sync_next_tick");

    // sync coincident with a tick suppresses that tick.
    for (int k = 0; k < DIV && m_pre != DIV - 1; k++) step();
    bus_if.sync = 1'b1;
    step();
    bus_if.sync = 1'b0;
    check("sync_over_tick", 32'(tick_s), 0);
    cycles_to_tick("sync2_next_tick");

    // One-cycle reset mid-blink.
    for (int k = 0; k < 47; k++) step();
    sys_rst = 1'b1;
    step();
    check("midrst_led", 32'(led_s), 0);
    check("midrst_tick", 32'(tick_s), 0);
    sys_rst = 1'b0;
    step();
    check("postrst_ch0_lit", 32'(led_s[0]), 1);
    check("postrst_ch3_lit", 32'(led_s[3]), 1);
    for (int k = 0; k < 200; k++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
